// File: rtl/lsu_ram_master.sv
// Load/store unit between the core memory stage and a word-wide, synchronous-read
// data RAM. Turns RV32I byte/half/word loads and stores into RAM cycles. Loads get
// lane extraction and sign/zero extension. Sub-word stores use read-modify-write.
// Misaligned accesses and undefined funct3 values complete with a fault.
module lsu_ram_master #(
  parameter int unsigned ADDRWIDTH = 6,
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iReq,
  input  logic                 iWE,
  input  logic [2:0]           iFunct3,
  input  logic [31:0]          iAddr,
  input  logic [31:0]          iWData,
  output logic                 oBusy,
  output logic                 oDone,
  output logic                 oFault,
  output logic [DATAWIDTH-1:0] oRData,
  output logic                 oRamWR,
  output logic [ADDRWIDTH-1:0] oRamAddress,
  output logic [DATAWIDTH-1:0] oRamWriteData,
  input  logic [DATAWIDTH-1:0] iRamReadData
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_EXT,
    S_MRG,
    S_WR,
    S_ERR
  } state_t;

  state_t               state;
  logic                 req_we;
  logic [2:0]           req_f3;
  logic [ADDRWIDTH+1:0] req_addr;
  logic [31:0]          req_wdata;

  logic                 req_illegal;
  logic [31:0]          load_result;
  logic [31:0]          merged_word;
  logic [7:0]           byte_lane;
  logic [15:0]          half_lane;

  // Address bits above the RAM range are intentionally discarded (accesses wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^iAddr[31:ADDRWIDTH+2];

  // Legality of the incoming request: alignment plus defined funct3 for the direction.
  always_comb begin
    req_illegal = 1'b0;
    case (iFunct3)
      F3_B:    req_illegal = 1'b0;
      F3_H:    req_illegal = iAddr[0];
      F3_W:    req_illegal = |iAddr[1:0];
      F3_BU:   req_illegal = iWE;
      F3_HU:   req_illegal = iWE | iAddr[0];
      default: req_illegal = 1'b1;
    endcase
  end

  // Load path: pick the addressed byte/half lane and extend it into a full word.
  always_comb begin
    byte_lane   = 8'h00;
    half_lane   = 16'h0000;
    load_result = iRamReadData[31:0];
    case (req_addr[1:0])
      2'd0:    byte_lane = iRamReadData[7:0];
      2'd1:    byte_lane = iRamReadData[15:8];
      2'd2:    byte_lane = iRamReadData[23:16];
      default: byte_lane = iRamReadData[31:24];
    endcase
    half_lane = req_addr[1] ? iRamReadData[31:16] : iRamReadData[15:0];
    case (req_f3)
      F3_B:    load_result = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    load_result = {{16{half_lane[15]}}, half_lane};
      F3_BU:   load_result = {24'h000000, byte_lane};
      F3_HU:   load_result = {16'h0000, half_lane};
      default: load_result = iRamReadData[31:0];
    endcase
  end

  // Sub-word store path: splice the new byte/half into the word just read back.
  always_comb begin
    merged_word = iRamReadData[31:0];
    if (req_f3 == F3_H) begin
      if (req_addr[1]) merged_word[31:16] = req_wdata[15:0];
      else             merged_word[15:0]  = req_wdata[15:0];
    end else begin
      case (req_addr[1:0])
        2'd0:    merged_word[7:0]   = req_wdata[7:0];
        2'd1:    merged_word[15:8]  = req_wdata[7:0];
        2'd2:    merged_word[23:16] = req_wdata[7:0];
        default: merged_word[31:24] = req_wdata[7:0];
      endcase
    end
  end

  // RAM-side strobes are decoded from state so an async reset drops a write at once.
  always_comb begin
    oBusy         = (state != S_IDLE);
    oRamWR        = (state == S_MRG) || (state == S_WR);
    oRamAddress   = req_addr[ADDRWIDTH+1:2];
    oRamWriteData = '0;
    if (state == S_WR)       oRamWriteData = req_wdata;
    else if (state == S_MRG) oRamWriteData = merged_word;
  end

  // Access sequencer: request capture, RAM cycle ordering and registered completion.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state     <= S_IDLE;
      req_we    <= 1'b0;
      req_f3    <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      oDone     <= 1'b0;
      oFault    <= 1'b0;
      oRData    <= '0;
    end else begin
      oDone <= 1'b0;
      case (state)
        S_IDLE: begin
          if (iReq) begin
            req_we    <= iWE;
            req_f3    <= iFunct3;
            req_addr  <= iAddr[ADDRWIDTH+1:0];
            req_wdata <= iWData;
            if (req_illegal)              state <= S_ERR;
            else if (iWE && iFunct3 == F3_W) state <= S_WR;
            else                          state <= S_RD;
          end
        end
        S_RD: begin
          state <= req_we ? S_MRG : S_EXT;
        end
        S_EXT: begin
          oRData <= load_result;
          oDone  <= 1'b1;
          oFault <= 1'b0;
          state  <= S_IDLE;
        end
        S_MRG, S_WR: begin
          oDone  <= 1'b1;
          oFault <= 1'b0;
          state  <= S_IDLE;
        end
        S_ERR: begin
          oDone  <= 1'b1;
          oFault <= 1'b1;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ram_master.sv
// Directed bench for lsu_ram_master with a small synchronous-read RAM model.
module tb_lsu_ram_master;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic        iReq;
  logic        iWE;
  logic [2:0]  iFunct3;
  logic [31:0] iAddr;
  logic [31:0] iWData;
  logic        oBusy;
  logic        oDone;
  logic        oFault;
  logic [31:0] oRData;
  logic        oRamWR;
  logic [5:0]  oRamAddress;
  logic [31:0] oRamWriteData;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:63];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  int total = 0;
  int bad   = 0;

  int          r_dcyc;
  int          r_ndone;
  int          r_nwr;
  int          r_wrcyc;
  logic [5:0]  r_waddr;
  logic [31:0] r_wdat;
  logic        r_fault;
  logic [31:0] r_rdata;

  lsu_ram_master #(.ADDRWIDTH(6), .DATAWIDTH(32)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iReq(iReq), .iWE(iWE), .iFunct3(iFunct3),
    .iAddr(iAddr), .iWData(iWData), .oBusy(oBusy), .oDone(oDone), .oFault(oFault),
    .oRData(oRData), .oRamWR(oRamWR), .oRamAddress(oRamAddress),
    .oRamWriteData(oRamWriteData), .iRamReadData(ram_rdata)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) begin
    if (pre_we)      mem[pre_addr] <= pre_data;
    else if (oRamWR) mem[oRamAddress] <= oRamWriteData;
    ram_rdata <= mem[oRamAddress];
  end

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    @(negedge iClk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge iClk);
    pre_we = 1'b0;
  endtask

  // Cycle 0 presents the request; cycles 1..8 are observed.
  task automatic do_access(input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
    @(negedge iClk);
    iReq = 1'b1; iWE = we; iFunct3 = f3; iAddr = a; iWData = wd;
    r_dcyc = -1; r_ndone = 0; r_nwr = 0; r_wrcyc = -1;
    r_waddr = '0; r_wdat = '0; r_fault = 1'bx; r_rdata = 'x;
    for (int c = 1; c <= 8; c++) begin
      @(negedge iClk);
      iReq = 1'b0;
      if (oRamWR) begin
        r_nwr++; r_waddr = oRamAddress; r_wdat = oRamWriteData; r_wrcyc = c;
      end
      if (oDone) begin
        r_ndone++;
        if (r_dcyc < 0) begin
          r_dcyc = c; r_fault = oFault; r_rdata = oRData;
        end
      end
    end
  endtask

  task automatic test_reset;
    iRst_n = 1'b0; iReq = 1'b0; iWE = 1'b0; iFunct3 = '0; iAddr = '0; iWData = '0;
    #3;
    total++;
    if ({oBusy, oDone, oFault, oRamWR} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {oBusy, oDone, oFault, oRamWR});
    end
    total++;
    if (oRData !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", oRData); end
    total++;
    if (oRamAddress !== 6'd0 || oRamWriteData !== 32'h0) begin
      bad++; $display("FAIL reset_ram got=%h/%h want=0/0", oRamAddress, oRamWriteData);
    end
    @(negedge iClk);
    iRst_n = 1'b1;
  endtask

  task automatic test_loads;
    logic [2:0]  f3 [5]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] ad [5]  = '{32'h7, 32'h7, 32'h6, 32'h4, 32'h4};
    logic [31:0] ex [5]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
    preload(6'd1, 32'h80FF7F01);
    for (int i = 0; i < 5; i++) begin
      do_access(1'b0, f3[i], ad[i], 32'h0);
      total++;
      if (r_rdata !== ex[i]) begin bad++; $display("FAIL load%0d_data got=%h want=%h", i, r_rdata, ex[i]); end
      total++;
      if (r_dcyc !== 3 || r_ndone !== 1) begin
        bad++; $display("FAIL load%0d_done got=cyc%0d n%0d want=cyc3 n1", i, r_dcyc, r_ndone);
      end
      total++;
      if (r_fault !== 1'b0 || r_nwr !== 0) begin
        bad++; $display("FAIL load%0d_fault got=f%b wr%0d want=f0 wr0", i, r_fault, r_nwr);
      end
    end
  endtask

  task automatic test_sub_stores;
    do_access(1'b1, 3'b000, 32'h5, 32'h123456AA);
    total++;
    if (r_nwr !== 1 || r_waddr !== 6'd1 || r_wdat !== 32'h80FFAA01 || r_wrcyc !== 2) begin
      bad++; $display("FAIL sb_write got=n%0d a%0d d%h c%0d want=n1 a1 d80ffaa01 c2", r_nwr, r_waddr, r_wdat, r_wrcyc);
    end
    total++;
    if (r_dcyc !== 3 || r_fault !== 1'b0) begin
      bad++; $display("FAIL sb_done got=cyc%0d f%b want=cyc3 f0", r_dcyc, r_fault);
    end
    total++;
    if (r_rdata !== 32'h80FF7F01) begin bad++; $display("FAIL sb_rdata_kept got=%h want=80ff7f01", r_rdata); end
    do_access(1'b0, 3'b010, 32'h4, 32'h0);
    total++;
    if (r_rdata !== 32'h80FFAA01) begin bad++; $display("FAIL sb_readback got=%h want=80ffaa01", r_rdata); end

    preload(6'd1, 32'h80FF7F01);
    do_access(1'b1, 3'b001, 32'h6, 32'h0000BEEF);
    total++;
    if (r_nwr !== 1 || r_waddr !== 6'd1 || r_wdat !== 32'hBEEF7F01) begin
      bad++; $display("FAIL sh_write got=n%0d a%0d d%h want=n1 a1 dbeef7f01", r_nwr, r_waddr, r_wdat);
    end
    do_access(1'b0, 3'b010, 32'h4, 32'h0);
    total++;
    if (r_rdata !== 32'hBEEF7F01) begin bad++; $display("FAIL sh_readback got=%h want=beef7f01", r_rdata); end

    do_access(1'b1, 3'b010, 32'h8, 32'hDEADBEEF);
    total++;
    if (r_nwr !== 1 || r_wrcyc !== 1 || r_waddr !== 6'd2 || r_wdat !== 32'hDEADBEEF) begin
      bad++; $display("FAIL sw_write got=n%0d c%0d a%0d d%h want=n1 c1 a2 ddeadbeef", r_nwr, r_wrcyc, r_waddr, r_wdat);
    end
    total++;
    if (r_dcyc !== 2) begin bad++; $display("FAIL sw_done got=cyc%0d want=cyc2", r_dcyc); end
    do_access(1'b0, 3'b010, 32'h8, 32'h0);
    total++;
    if (r_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_readback got=%h want=deadbeef", r_rdata); end
  endtask

  task automatic test_wrap;
    do_access(1'b1, 3'b010, 32'h00000108, 32'h55AA55AA);
    total++;
    if (r_waddr !== 6'd2 || r_nwr !== 1) begin
      bad++; $display("FAIL wrap_store got=a%0d n%0d want=a2 n1", r_waddr, r_nwr);
    end
    do_access(1'b0, 3'b010, 32'h8, 32'h0);
    total++;
    if (r_rdata !== 32'h55AA55AA) begin bad++; $display("FAIL wrap_readback got=%h want=55aa55aa", r_rdata); end
    do_access(1'b0, 3'b010, 32'hFFFFFF04, 32'h0);
    total++;
    if (r_rdata !== 32'hBEEF7F01) begin bad++; $display("FAIL wrap_load got=%h want=beef7f01", r_rdata); end
  endtask

  task automatic test_faults;
    logic        we [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3 [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic [31:0] ad [4] = '{32'h6, 32'h5, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      do_access(we[i], f3[i], ad[i], 32'hFFFFFFFF);
      total++;
      if (r_fault !== 1'b1 || r_dcyc !== 2 || r_ndone !== 1) begin
        bad++; $display("FAIL fault%0d_done got=f%b cyc%0d n%0d want=f1 cyc2 n1", i, r_fault, r_dcyc, r_ndone);
      end
      total++;
      if (r_nwr !== 0 || r_rdata !== 32'hBEEF7F01) begin
        bad++; $display("FAIL fault%0d_side got=wr%0d rd%h want=wr0 rdbeef7f01", i, r_nwr, r_rdata);
      end
    end
    total++;
    if (oFault !== 1'b1) begin bad++; $display("FAIL fault_held got=%b want=1", oFault); end
  endtask

  task automatic test_back_to_back;
    int dc;
    int got;
    @(negedge iClk);
    iReq = 1'b1; iWE = 1'b1; iFunct3 = 3'b010; iAddr = 32'hC; iWData = 32'h11112222;
    dc = -1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge iClk);
      iReq = 1'b0;
      if (oDone) begin dc = c; break; end
    end
    total++;
    if (dc !== 2 || oFault !== 1'b0) begin
      bad++; $display("FAIL b2b_first got=cyc%0d f%b want=cyc2 f0", dc, oFault);
    end
    iReq = 1'b1; iWE = 1'b0; iFunct3 = 3'b010; iAddr = 32'hC; iWData = 32'h0;
    @(negedge iClk);
    iReq = 1'b0;
    total++;
    if (oBusy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", oBusy); end
    got = -1;
    for (int c = 2; c <= 8; c++) begin
      @(negedge iClk);
      if (oDone && got < 0) begin
        got = c;
        total++;
        if (oRData !== 32'h11112222) begin bad++; $display("FAIL b2b_data got=%h want=11112222", oRData); end
      end
    end
    total++;
    if (got !== 3) begin bad++; $display("FAIL b2b_second got=cyc%0d want=cyc3", got); end
  endtask

  task automatic test_busy_ignore;
    int nd;
    int nw;
    logic [31:0] rd;
    @(negedge iClk);
    iReq = 1'b1; iWE = 1'b0; iFunct3 = 3'b010; iAddr = 32'h4; iWData = 32'h0;
    nd = 0; nw = 0; rd = 'x;
    for (int c = 1; c <= 8; c++) begin
      @(negedge iClk);
      if (c == 1 || c == 2) begin
        iReq = 1'b1; iWE = 1'b1; iFunct3 = 3'b010; iAddr = 32'h4; iWData = 32'h0;
      end else begin
        iReq = 1'b0;
      end
      if (oRamWR) nw++;
      if (oDone) begin nd++; rd = oRData; end
    end
    total++;
    if (nd !== 1 || nw !== 0) begin bad++; $display("FAIL busy_ignore got=done%0d wr%0d want=done1 wr0", nd, nw); end
    total++;
    if (rd !== 32'hBEEF7F01) begin bad++; $display("FAIL busy_data got=%h want=beef7f01", rd); end
  endtask

  task automatic test_reset_mid;
    preload(6'd1, 32'h80FF7F01);
    @(negedge iClk);
    iReq = 1'b1; iWE = 1'b1; iFunct3 = 3'b000; iAddr = 32'h5; iWData = 32'h000000CC;
    @(negedge iClk);
    iReq = 1'b0;
    @(negedge iClk);
    total++;
    if (oRamWR !== 1'b1) begin bad++; $display("FAIL mid_in_mrg got=%b want=1", oRamWR); end
    #1 iRst_n = 1'b0;
    #1;
    total++;
    if ({oRamWR, oBusy, oDone, oFault} !== 4'b0000) begin
      bad++; $display("FAIL mid_flags got=%b want=0000", {oRamWR, oBusy, oDone, oFault});
    end
    total++;
    if (oRData !== 32'h0 || oRamAddress !== 6'd0 || oRamWriteData !== 32'h0) begin
      bad++; $display("FAIL mid_values got=%h/%h/%h want=0/0/0", oRData, oRamAddress, oRamWriteData);
    end
    @(negedge iClk);
    iRst_n = 1'b1;
    total++;
    if (mem[1] !== 32'h80FF7F01) begin bad++; $display("FAIL mid_mem got=%h want=80ff7f01", mem[1]); end
    do_access(1'b0, 3'b010, 32'h4, 32'h0);
    total++;
    if (r_rdata !== 32'h80FF7F01 || r_dcyc !== 3 || r_fault !== 1'b0) begin
      bad++; $display("FAIL mid_after got=%h cyc%0d f%b want=80ff7f01 cyc3 f0", r_rdata, r_dcyc, r_fault);
    end
  endtask

  initial begin
    test_reset;
    test_loads;
    test_sub_stores;
    test_wrap;
    test_faults;
    test_back_to_back;
    test_busy_ignore;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_ram_master.md
Name: lsu_ram_master

Overview:
- Load/store access unit that sits between the core's memory stage and the word-wide synchronous-read data RAM.
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into RAM cycles. The RAM has a registered read address with data available the following cycle, and only whole-word writes.
- Performs byte/halfword extraction and sign/zero extension on loads.
- Performs read-modify-write for sub-word stores.
- Flags misaligned or illegal accesses.

Parameters:
- ADDRWIDTH, 6: RAM word-address width; RAM depth = 1<<ADDRWIDTH words.
- DATAWIDTH, 32: data width; fixed at 32, byte lanes assume 4 bytes.

Ports:
- iClk  in  1  clock, rising edge.
- iRst_n  in  1  asynchronous active-low reset.
- iReq  in  1  request strobe; sampled only in IDLE.
- iWE  in  1  1 = store, 0 = load.
- iFunct3  in  3  RV funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- iAddr  in  32  byte address.
- iWData  in  32  store data; low byte/half used for SB/SH.
- oBusy  out  1  high whenever state != IDLE.
- oDone  out  1  one-cycle completion pulse.
- oFault  out  1  valid with oDone; held until the next oDone.
- oRData  out  32  load result; updated only on load completion.
- oRamWR  out  1  RAM write enable.
- oRamAddress  out  ADDRWIDTH  RAM word address.
- oRamWriteData  out  32  RAM write data.
- iRamReadData  in  32  RAM read data; reflects the address presented in the previous cycle.

Behaviour:
- Reset (async, iRst_n=0):
  - State = IDLE; all request registers cleared.
  - oDone=0, oFault=0, oRData=0.
  - oRamWR=0 immediately, because it is decoded from state; oRamAddress=0; oBusy=0.
- IDLE:
  - On iReq=1, register iWE, iFunct3, iAddr, iWData.
  - Next state:
    - ERR if the access is illegal.
    - WR for SW.
    - RD for all loads, SB and SH.
  - iReq is ignored in any other state; no queuing.
- Illegal access:
  - Misaligned: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0.
  - Undefined funct3: 011, 110, 111 for loads; anything other than 000/001/010 for stores.
- RD: oRamAddress = latched addr[ADDRWIDTH+1:2]; oRamWR=0. Next state: EXT for loads, MRG for sub-word stores.
- EXT: iRamReadData is valid. Select byte lane addr[1:0] or half lane addr[1]. Sign-extend for B/H, zero-extend for BU/HU, pass through for W. Register the result into oRData. Go to IDLE.
- MRG:
  - oRamWR=1, comb.
  - oRamWriteData = iRamReadData with the addressed lane replaced: SB uses wdata[7:0] into lane addr[1:0]; SH uses wdata[15:0] into lane addr[1]. Lane order is little-endian.
  - Go to IDLE.
- WR: oRamWR=1; oRamWriteData = latched wdata; go to IDLE.
- ERR: no RAM access; go to IDLE.
- Completion:
  - oDone is registered and set on the edge leaving EXT/MRG/WR/ERR.
  - oFault is set on the edge leaving ERR and cleared on the edge leaving any other completing state.
  - oRData is unchanged by stores and faults.
- oRamWriteData = 0 whenever oRamWR=0.
- Latency (accept edge = edge 0):
  - Load: oDone high after edge 3.
  - SB/SH: oDone high after edge 3.
  - SW: oDone high after edge 2.
  - Fault: oDone high after edge 2.
- Back-to-back: the cycle with oDone=1 is IDLE, so iReq is accepted in that same cycle.
- Upper address bits above ADDRWIDTH+1 are ignored, so addresses wrap modulo RAM size.
- Reset mid-operation: an access aborted in RD or EXT has no side effects. An abort in MRG/WR before the clock edge produces no RAM write.

Test Plan:
- Preload mem[1]=0x80FF7F01, then issue:
  - LB 0x7 -> oRData=0xFFFFFF80.
  - LBU 0x7 -> 0x00000080.
  - LH 0x6 -> 0xFFFF80FF.
  - LHU 0x4 -> 0x00007F01.
  - LW 0x4 -> 0x80FF7F01.
  - Each completes with oDone on the 3rd cycle after accept and oFault=0.
- SB 0x5 with iWData=0x123456AA -> exactly one oRamWR pulse, at oRamAddress=1 with data 0x80FFAA01. A following LW 0x4 returns 0x80FFAA01.
- SH 0x6 with 0x0000BEEF -> mem[1]=0xBEEF7F01. SW 0x8 with 0xDEADBEEF -> oRamWR in the cycle after accept and oDone 2 cycles after accept. LW 0x8 then returns 0xDEADBEEF.
- Error cases, each giving oDone with oFault=1, no oRamWR, and oRData unchanged:
  - LW 0x6.
  - SH 0x5.
  - funct3=011 load.
  - funct3=100 store.
- Back-to-back and busy handling:
  - Assert iReq in the oDone cycle of a preceding SW -> accepted, oBusy stays high.
  - Assert iReq while busy -> ignored; no extra oDone.
- Reset mid-operation:
  - Assert iRst_n=0 during MRG of an SB (before the edge) -> oRamWR drops immediately, memory word is unchanged, all outputs return to reset values.
  - Next access after reset works normally.
